image_eth_formatter: RTL and testbench
======================================

Name: image_eth_formatter

Overview:
Packs the 1-bit Sobel edge stream from the pixel pipeline into bytes and writes them to the Ethernet TX FIFO. Each image line becomes ceil(W/8) packed pixel bytes followed by a 2-byte line-index trailer. Pulses an asynchronous clear to the FIFO at each frame start, so every frame starts from an empty FIFO. Sits between the Sobel edge detector and the Ethernet TX FIFO, in the pixel clock domain.

Parameters:
MSB_FIRST, 1, 1: first pixel of each byte goes in bit 7; 0: first pixel goes in bit 0.
ROW_CNT_W, 16, line counter width (1..16); zero-extended to 16 bits in the trailer.

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
valid  in  1  pixel-valid qualifier.
hsync  in  1  line-active: high for the whole line, including the cycle of the last pixel.
vsync  in  1  frame-active: high for the whole frame, including the last pixel.
sobel  in  1  binary edge pixel.
fifo_aclr  out  1  FIFO asynchronous clear, active high.
write_data  out  8  byte to the FIFO.
write_req  out  1  one-cycle write strobe; write_data is valid while it is high.

Behaviour:
- All outputs are registered. Reset values: fifo_aclr=1 (FIFO held clear during reset), write_req=0, write_data=0x00. Internal state resets to IDLE, with shift register, bit count and line counter all at 0.
- Pixel capture: a pixel is accepted at a rising edge where valid & hsync & vsync are all 1. Accepted pixels shift into an 8-bit register in the order set by MSB_FIRST.
- When the 8th bit is accepted at edge P, write_req=1 with the packed byte during the cycle after P (latency 1). Bit count returns to 0.
- Frame start: vsync sampled 1 while the previous sample was 0. Action: fifo_aclr=1 for exactly one cycle after that edge; line counter and bit count cleared. A pixel accepted on that same edge is kept as pixel 0.
- Line end: hsync sampled 0 while the previous sample was 1 (first edge after the last pixel, P+1). Required output sequence:
  - If bit count is not 0, emit the partial byte zero-padded in the unfilled positions at P+1. Then line index bits [15:8] at P+2 and bits [7:0] at P+3.
  - Otherwise emit the index high byte at P+1 and the low byte at P+2.
  - Then the line counter increments (wraps at 2^ROW_CNT_W) and bit count clears.
- FSM states: IDLE -> LINE (first accepted pixel) -> FLUSH (only if a partial byte is pending) -> TAIL_HI -> TAIL_LO -> IDLE.
- Upstream guarantee: at least 3 idle cycles between the last pixel of a line and the first pixel of the next. Pixels accepted during FLUSH/TAIL_* are dropped.
- vsync falling: no extra output. The final line's trailer is still emitted because hsync falls on the same edge.
- valid low inside a line: no shift, no output. The line continues.
- At most one write_req per cycle. write_data holds its last value when write_req=0.
- Reset mid-operation aborts any pending byte or trailer immediately, with no partial write.

Optional Feature:
Macro IMG_ETH_FRAME_HEADER_EN.
- Defined: two edges after the frame-start edge, emit 0xAA then 0x55 on consecutive cycles as a frame marker, after the fifo_aclr pulse.
  - Pixel packing continues in parallel; the first pixel byte cannot arrive before 8 accepted pixels, so there is no collision.
- Undefined: no header; the frame begins directly with pixel bytes.

Decomposition:
Shared package img_eth_pkg holds:
- FSM state typedef (IDLE, LINE, FLUSH, TAIL_HI, TAIL_LO).
- Header byte constants 0xAA and 0x55.
- Trailer length constant 2.

One natural sub-module, bit_packer8: shift register, bit counter, byte-ready and flush logic. Edge detection, FSM, line counter and output mux stay in the top.

Test Plan:
1. Reset held 10 cycles -> fifo_aclr=1 and write_req=0 throughout; fifo_aclr=0 after release.
2. Frame of 3 lines x 16 pixels:
   - line 0: 8x"1" then 0,1,0,1,0,1,0,1 -> bytes 0xFF,0x55,0x00,0x00.
   - line 1: all 1 -> 0xFF,0xFF,0x00,0x01.
   - line 2: all 0 -> 0x00,0x00,0x00,0x02.
   - Total 12 write_req pulses; one fifo_aclr pulse at frame start.
3. Second identical frame after 3 idle cycles -> a second fifo_aclr pulse, line index restarts at 0, same 12 bytes.
4. 12-pixel line of all 1 -> 0xFF, then 0xF0 (padded) at P+1, then trailer at P+2/P+3.
5. valid dropped for 4 cycles mid-line -> identical bytes, with only the write timing shifted.
6. With IMG_ETH_FRAME_HEADER_EN defined -> 0xAA,0x55 precede the 12 bytes of each frame (14 writes per frame).

Source files
------------

// File: rtl/img_eth_pkg.sv
// rtl/img_eth_pkg.sv - shared types and constants for the image-to-Ethernet byte formatter
// Contents: formatter FSM state type, frame-marker byte values, line trailer length.
package img_eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LINE,
        FLUSH,
        TAIL_HI,
        TAIL_LO
    } fmt_state_t;

    localparam logic [7:0] HDR_BYTE0   = 8'hAA;
    localparam logic [7:0] HDR_BYTE1   = 8'h55;
    localparam int         TRAILER_LEN = 2;

endpackage

// File: rtl/bit_packer8.sv
// rtl/bit_packer8.sv - packs a 1-bit pixel stream into bytes with zero-padded partial flush
// Ports:
//   clk_pixel, rst_n    : pixel clock, asynchronous active-low reset
//   clear               : frame start; restarts packing (a pixel accepted on this edge is pixel 0)
//   accept, pixel       : pixel strobe and value
//   flush               : line end; discards the bit count after the partial byte is taken
//   byte_ready/byte_data: combinational, the edge that accepts the 8th bit completes byte_data
//   pending/flush_data  : a partial byte is held; flush_data is it zero-padded
module bit_packer8 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       accept,
    input  logic       pixel,
    input  logic       flush,
    output logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       pending,
    output logic [7:0] flush_data
);

    logic [7:0] sr;
    logic [7:0] sr_base;
    logic [7:0] sr_next;
    logic [2:0] cnt;
    logic [2:0] cnt_base;
    logic [3:0] pad;

    always_comb begin
        sr_base    = clear ? 8'h00 : sr;
        cnt_base   = clear ? 3'd0 : cnt;
        sr_next    = MSB_FIRST ? {sr_base[6:0], pixel} : {pixel, sr_base[7:1]};
        byte_ready = accept && (cnt_base == 3'd7);
        byte_data  = sr_next;
        pending    = (cnt != 3'd0);
        // Shifting by the unfilled count pushes stale bits out and zeros in.
        pad        = 4'd8 - {1'b0, cnt};
        flush_data = MSB_FIRST ? (sr << pad) : (sr >> pad);
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= 8'h00;
            cnt <= 3'd0;
        end else if (accept) begin
            sr  <= sr_next;
            cnt <= cnt_base + 3'd1;
        end else if (clear || flush) begin
            cnt <= 3'd0;
        end
    end

endmodule

// File: rtl/image_eth_formatter.sv
// rtl/image_eth_formatter.sv - formats the Sobel edge stream into bytes for the Ethernet TX FIFO
// Ports:
//   clk_pixel, rst_n         : pixel clock, asynchronous active-low reset
//   valid, hsync, vsync      : pixel qualifier, line-active, frame-active
//   sobel                    : 1-bit edge pixel
//   fifo_aclr                : one-cycle FIFO clear after each frame start (held high in reset)
//   write_data, write_req    : byte and one-cycle write strobe to the FIFO
// Each line: ceil(W/8) packed bytes, then a 16-bit line index (high byte first).
// Build option IMG_ETH_FRAME_HEADER_EN: emit 0xAA,0x55 two and three edges after frame start.
module image_eth_formatter
    import img_eth_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int ROW_CNT_W = 16
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic       valid,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       sobel,
    output logic       fifo_aclr,
    output logic [7:0] write_data,
    output logic       write_req
);

    fmt_state_t           state;
    logic                 vsync_q;
    logic                 hsync_q;
    logic [ROW_CNT_W-1:0] line_cnt;
    logic [15:0]          line_idx;
    logic                 frame_start;
    logic                 line_end;
    logic                 accept;
    logic                 flush;
    logic                 byte_ready;
    logic [7:0]           byte_data;
    logic                 pending;
    logic [7:0]           flush_data;

    assign line_idx    = 16'(line_cnt);
    assign frame_start = vsync & ~vsync_q;
    assign line_end    = hsync_q & ~hsync;
    // TAIL_LO is the cycle after the last trailer byte went out, so a new line may start there.
    assign accept      = valid & hsync & vsync &
                         ((state == IDLE) || (state == LINE) || (state == TAIL_LO));
    assign flush       = (state == LINE) && line_end;

    bit_packer8 #(
        .MSB_FIRST(MSB_FIRST)
    ) u_packer (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .accept    (accept),
        .pixel     (sobel),
        .flush     (flush),
        .byte_ready(byte_ready),
        .byte_data (byte_data),
        .pending   (pending),
        .flush_data(flush_data)
    );

`ifdef IMG_ETH_FRAME_HEADER_EN
    logic [2:0] hdr_sr;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            hdr_sr <= 3'b000;
        end else begin
            hdr_sr <= {hdr_sr[1:0], frame_start};
        end
    end
`endif

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            line_cnt   <= '0;
            fifo_aclr  <= 1'b1;
            write_req  <= 1'b0;
            write_data <= 8'h00;
        end else begin
            vsync_q   <= vsync;
            hsync_q   <= hsync;
            fifo_aclr <= frame_start;
            write_req <= 1'b0;

            if (byte_ready) begin
                write_req  <= 1'b1;
                write_data <= byte_data;
            end

            // State names the byte that was written on the edge that entered it.
            case (state)
                IDLE, TAIL_LO: begin
                    state <= accept ? LINE : IDLE;
                end
                LINE: begin
                    if (line_end) begin
                        write_req <= 1'b1;
                        if (pending) begin
                            write_data <= flush_data;
                            state      <= FLUSH;
                        end else begin
                            write_data <= line_idx[15:8];
                            state      <= TAIL_HI;
                        end
                    end
                end
                FLUSH: begin
                    write_req  <= 1'b1;
                    write_data <= line_idx[15:8];
                    state      <= TAIL_HI;
                end
                TAIL_HI: begin
                    write_req  <= 1'b1;
                    write_data <= line_idx[7:0];
                    line_cnt   <= line_cnt + ROW_CNT_W'(1);
                    state      <= TAIL_LO;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (frame_start) begin
                line_cnt <= '0;
            end

`ifdef IMG_ETH_FRAME_HEADER_EN
            // First pixel byte needs 8 pixels, so the marker never meets packed data.
            if (hdr_sr[1]) begin
                write_req  <= 1'b1;
                write_data <= HDR_BYTE0;
            end else if (hdr_sr[2]) begin
                write_req  <= 1'b1;
                write_data <= HDR_BYTE1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_image_eth_formatter.sv
// tb/tb_image_eth_formatter.sv - self-checking bench for image_eth_formatter
module tb_image_eth_formatter;
    import img_eth_pkg::*;

    localparam bit MSB = 1'b1;

    logic       clk_pixel = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       sobel;
    logic       fifo_aclr;
    logic [7:0] write_data;
    logic       write_req;

    image_eth_formatter dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .valid     (valid),
        .hsync     (hsync),
        .vsync     (vsync),
        .sobel     (sobel),
        .fifo_aclr (fifo_aclr),
        .write_data(write_data),
        .write_req (write_req)
    );

    always #5 clk_pixel = ~clk_pixel;

    int   cyc = 0;
    logic rst_edge = 1'b0;
    always @(posedge clk_pixel) begin
        cyc      <= cyc + 1;
        rst_edge <= rst_n;
    end

    int checks = 0;
    int passes = 0;
    int fs_edge = -1;
    int aclr_pulses = 0;
    int frames = 0;
    int m_line = 0;
    int p_edge;
    logic [7:0] exp_q[$];
    logic [7:0] scratch[$];
    int         wr_cyc[$];
    logic       in_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: a line is its pixels grouped 8 at a time (first pixel in bit 7 when MSB),
    // zero-padded, followed by the line index high byte then low byte.
    function automatic void model_line(input logic [31:0] pat, input int n, input int idx);
        logic [7:0]  b;
        logic [15:0] li;
        scratch.delete();
        for (int j = 0; j < (n + 7) / 8; j++) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (8 * j + k < n) begin
                    if (MSB) b[7-k] = pat[8*j+k];
                    else     b[k]   = pat[8*j+k];
                end
            end
            scratch.push_back(b);
        end
        li = 16'(idx);
        for (int t = 0; t < TRAILER_LEN; t++) scratch.push_back(8'(li >> (8 * (TRAILER_LEN - 1 - t))));
    endfunction

    always @(negedge clk_pixel) begin
        in_rst = !rst_n || !rst_edge;
        check("fifo_aclr", fifo_aclr, in_rst || (cyc == fs_edge));
        if (fifo_aclr && !in_rst) aclr_pulses++;
        if (in_rst) begin
            check("write_req_in_reset", write_req, 0);
            check("write_data_in_reset", write_data, 0);
        end else if (write_req) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got %0h, expected no write (cycle %0d)", write_data, cyc);
            end else begin
                check("write_data", write_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic h, input logic vs, input logic s);
        valid = v; hsync = h; vsync = vs; sobel = s;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic start_frame();
        frames++;
        m_line = 0;
`ifdef IMG_ETH_FRAME_HEADER_EN
        exp_q.push_back(HDR_BYTE0);
        exp_q.push_back(HDR_BYTE1);
`endif
    endtask

    task automatic send_line(input logic [31:0] pat, input int n, input int gap_at,
                             input bit first, input bit last, output int p);
        if (first) start_frame();
        model_line(pat, n, m_line);
        foreach (scratch[i]) exp_q.push_back(scratch[i]);
        m_line++;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b1, 1'b1, pat[i]);
            if (first && i == 0) fs_edge = cyc;
        end
        p = cyc;
        repeat (4) step(1'b0, 1'b0, !last, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; hsync = 1'b0; vsync = 1'b0; sobel = 1'b0;

        // Reset held 10 cycles; the compare process checks outputs every cycle.
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_aclr_held", fifo_aclr, 1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("aclr_after_release", fifo_aclr, 0);
        check("wreq_after_release", write_req, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Pin the reference against hand-computed bytes.
        model_line(32'h0000AAFF, 16, 0);
        check("model_l0_len", scratch.size(), 4);
        check("model_l0_b0", scratch[0], 8'hFF);
        check("model_l0_b1", scratch[1], 8'h55);
        check("model_l0_b3", scratch[3], 8'h00);
        model_line(32'h00000FFF, 12, 1);
        check("model_p12_b1", scratch[1], 8'hF0);
        check("model_p12_b3", scratch[3], 8'h01);

        // Two identical 3x16 frames.
        for (int f = 0; f < 2; f++) begin
            send_line(32'h0000AAFF, 16, -1, 1'b1, 1'b0, p_edge);
            send_line(32'h0000FFFF, 16, -1, 1'b0, 1'b0, p_edge);
            check("l16_last_byte_at_P", wr_cyc[$-2], p_edge);
            check("l16_tail_hi_at_P1", wr_cyc[$-1], p_edge + 1);
            check("l16_tail_lo_at_P2", wr_cyc[$], p_edge + 2);
            send_line(32'h00000000, 16, -1, 1'b0, 1'b1, p_edge);
        end

        // 12-pixel line: full byte at pixel 7, padded byte at P+1, trailer at P+2/P+3.
        send_line(32'h00000FFF, 12, -1, 1'b1, 1'b1, p_edge);
        check("l12_full_at_Pm4", wr_cyc[$-3], p_edge - 4);
        check("l12_pad_at_P1", wr_cyc[$-2], p_edge + 1);
        check("l12_tail_hi_at_P2", wr_cyc[$-1], p_edge + 2);
        check("l12_tail_lo_at_P3", wr_cyc[$], p_edge + 3);

        // valid low for 4 cycles mid-line.
        send_line(32'h00001E83, 16, 5, 1'b1, 1'b1, p_edge);
        check("gap_last_byte_at_P", wr_cyc[$-2], p_edge);

        // Reset right after the last pixel of a partial line: no padded byte, no trailer.
        start_frame();
        model_line(32'h00000FFF, 12, 0);
        exp_q.push_back(scratch[0]);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (i == 0) fs_edge = cyc;
        end
        rst_n = 1'b0; valid = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);

        check("expected_bytes_left", exp_q.size(), 0);
        check("aclr_pulse_count", aclr_pulses, frames);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
